// File: rtl/video_tpg_src.sv
// video_tpg_src: 1080p 4:2:2 10-bit test pattern source.
// Produces registered {f,v,h,t} timing plus colour-bar or flat-field video.
// h falls at the first active pixel, and v rises at pixel 0 of line 1.
module video_tpg_src #(
   parameter int H_BLANK  = 280,
   parameter int H_ACTIVE = 1920,
   parameter int V_BLANK  = 45,
   parameter int V_TOTAL  = 1125,
   parameter int BAR_W    = 240
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        cen_i,
   input  logic        pat_sel_i,
   input  logic [2:0]  flat_idx_i,
   output logic [3:0]  fvht_o,
   output logic [19:0] video_o,
   output logic [15:0] frame_cnt_o
);

   localparam logic [11:0] PIX_LAST  = 12'(H_BLANK + H_ACTIVE - 1);
   localparam logic [10:0] LINE_LAST = 11'(V_TOTAL);
   localparam logic [19:0] BLANK_VID = {10'd64, 10'd512};

   // Luma per bar index
   function automatic logic [9:0] y_of(input logic [2:0] idx);
      case (idx)
         3'd0:    return 10'd940;
         3'd1:    return 10'd646;
         3'd2:    return 10'd525;
         3'd3:    return 10'd450;
         3'd4:    return 10'd335;
         3'd5:    return 10'd260;
         3'd6:    return 10'd139;
         default: return 10'd64;
      endcase
   endfunction

   // Cb per bar index
   function automatic logic [9:0] cb_of(input logic [2:0] idx);
      case (idx)
         3'd0:    return 10'd512;
         3'd1:    return 10'd176;
         3'd2:    return 10'd625;
         3'd3:    return 10'd289;
         3'd4:    return 10'd735;
         3'd5:    return 10'd399;
         3'd6:    return 10'd848;
         default: return 10'd512;
      endcase
   endfunction

   // Cr per bar index
   function automatic logic [9:0] cr_of(input logic [2:0] idx);
      case (idx)
         3'd0:    return 10'd512;
         3'd1:    return 10'd567;
         3'd2:    return 10'd176;
         3'd3:    return 10'd231;
         3'd4:    return 10'd793;
         3'd5:    return 10'd848;
         3'd6:    return 10'd457;
         default: return 10'd512;
      endcase
   endfunction

   // Bar index from active offset by comparing against bar boundaries;
   // anything past the eighth boundary saturates at bar 7.
   function automatic logic [2:0] bar_of(input logic [11:0] a);
      logic [2:0] b;
      b = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (a >= 12'(k * BAR_W)) b = 3'(k);
      end
      return b;
   endfunction

   logic [11:0] pix_p0;
   logic [10:0] line_p0;
   logic        hblank;
   logic        vblank;
   logic        tmark;
   logic [11:0] act;
   logic [2:0]  idx;
   logic [3:0]  fvht_nxt;
   logic [19:0] video_nxt;

   // Decode the current raster position into the next output word
   always_comb begin
      hblank    = (pix_p0 < 12'(H_BLANK));
      vblank    = (line_p0 <= 11'(V_BLANK));
      tmark     = (pix_p0 == 12'd0);
      act       = pix_p0 - 12'(H_BLANK);
      idx       = pat_sel_i ? flat_idx_i : bar_of(act);
      fvht_nxt  = {1'b0, vblank, hblank, tmark};
      video_nxt = BLANK_VID;
      if (!(hblank || vblank)) begin
         video_nxt = {y_of(idx), act[0] ? cr_of(idx) : cb_of(idx)};
      end
   end

   // Raster counters and completed-frame count
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         pix_p0      <= 12'd0;
         line_p0     <= 11'd1;
         frame_cnt_o <= 16'd0;
      end else if (cen_i) begin
         if (pix_p0 == PIX_LAST) begin
            pix_p0 <= 12'd0;
            if (line_p0 == LINE_LAST) begin
               line_p0     <= 11'd1;
               frame_cnt_o <= frame_cnt_o + 16'd1;
            end else begin
               line_p0 <= line_p0 + 11'd1;
            end
         end else begin
            pix_p0 <= pix_p0 + 12'd1;
         end
      end
   end

   // Output register: one enabled cycle behind the counters
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         fvht_o  <= 4'b0110;
         video_o <= BLANK_VID;
      end else if (cen_i) begin
         fvht_o  <= fvht_nxt;
         video_o <= video_nxt;
      end
   end

endmodule
